// File: rtl/rcosine_pkg.sv
// rtl/rcosine_pkg.sv - shared raised-cosine coefficients, sequencer states and widths
package rcosine_pkg;

    localparam int RC_DSIZE  = 8;
    localparam int RC_COEF_W = 8;
    localparam int RC_PRE_W  = RC_DSIZE + 1;
    localparam int RC_PROD_W = 2 * RC_DSIZE + 1;
    localparam int RC_ACC_W  = 2 * RC_DSIZE + 3;

    // Symmetric 9-tap set: h0 h1 h2 h3 h4 h3 h2 h1 h0
    localparam logic [RC_COEF_W-1:0] RC_H0 = 8'h26;
    localparam logic [RC_COEF_W-1:0] RC_H1 = 8'h36;
    localparam logic [RC_COEF_W-1:0] RC_H2 = 8'h44;
    localparam logic [RC_COEF_W-1:0] RC_H3 = 8'h50;
    localparam logic [RC_COEF_W-1:0] RC_H4 = 8'h51;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4
    } seq_state_e;

endpackage

// File: rtl/rcosine_mac.sv
// rtl/rcosine_mac.sv - shared pre-adder, coefficient multiplier and accumulate adder
module rcosine_mac
    import rcosine_pkg::*;
#(
    parameter int DSIZE = RC_DSIZE
) (
    input  logic [DSIZE-1:0]     a_i,
    input  logic [DSIZE-1:0]     b_i,
    input  logic [RC_COEF_W-1:0] coef_i,
    input  logic [2*DSIZE+2:0]   acc_i,
    input  logic                 bypass_i,
    output logic [2*DSIZE+2:0]   sum_o
);

    localparam int PROD_W = 2 * DSIZE + 1;
    localparam int ACC_W  = 2 * DSIZE + 3;

    logic [DSIZE:0]    pre;
    logic [PROD_W-1:0] prod;

    always_comb begin
        pre   = {1'b0, a_i} + {1'b0, b_i};
        prod  = PROD_W'(pre) * PROD_W'(coef_i);
        // bypass starts a fresh phase sum instead of accumulating
        sum_o = (bypass_i ? '0 : acc_i) + ACC_W'(prod);
    end

endmodule

// File: rtl/rcosine_interp2.sv
// rtl/rcosine_interp2.sv - 2x polyphase raised-cosine interpolator with shared MAC
module rcosine_interp2
    import rcosine_pkg::*;
#(
    parameter int DSIZE = RC_DSIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sym_en,
    input  logic [DSIZE-1:0]     sym,
    output logic                 sym_rdy,
    output logic                 ovr,
    output logic                 dout_en,
    output logic [2*DSIZE+2:0]   dout
);

    localparam int ACC_W = 2 * DSIZE + 3;

    seq_state_e          state_q, state_d;
    logic [DSIZE-1:0]    s_q [5];
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    dout_q;
    logic                dout_en_q;
    logic                ovr_q;

    logic [DSIZE-1:0]    mac_a, mac_b;
    logic [RC_COEF_W-1:0] mac_coef;
    logic                mac_bypass;
    logic [ACC_W-1:0]    mac_sum;
    logic                accept;

    assign accept = (state_q == ST_IDLE) && sym_en;

    always_comb begin
        state_d    = state_q;
        mac_a      = s_q[0];
        mac_b      = s_q[4];
        mac_coef   = RC_H0;
        mac_bypass = 1'b1;
        case (state_q)
            ST_IDLE: if (sym_en) state_d = ST_M0;
            ST_M0: state_d = ST_M1;
            ST_M1: begin
                mac_a      = s_q[1];
                mac_b      = s_q[3];
                mac_coef   = RC_H2;
                mac_bypass = 1'b0;
                state_d    = ST_M2;
            end
            ST_M2: begin
                mac_a      = s_q[2];
                mac_b      = '0;
                mac_coef   = RC_H4;
                mac_bypass = 1'b0;
                state_d    = ST_M3;
            end
            ST_M3: begin
                mac_a    = s_q[0];
                mac_b    = s_q[3];
                mac_coef = RC_H1;
                state_d  = ST_M4;
            end
            ST_M4: begin
                mac_a      = s_q[1];
                mac_b      = s_q[2];
                mac_coef   = RC_H3;
                mac_bypass = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    rcosine_mac #(.DSIZE(DSIZE)) u_mac (
        .a_i      (mac_a),
        .b_i      (mac_b),
        .coef_i   (mac_coef),
        .acc_i    (acc_q),
        .bypass_i (mac_bypass),
        .sum_o    (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            ovr_q     <= 1'b0;
            for (int i = 0; i < 5; i++) s_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ovr_q     <= sym_en && (state_q != ST_IDLE);
            dout_en_q <= (state_q == ST_M2) || (state_q == ST_M4);
            if (accept) begin
                s_q[0] <= sym;
                for (int i = 1; i < 5; i++) s_q[i] <= s_q[i-1];
            end
            if (state_q == ST_M0 || state_q == ST_M1 || state_q == ST_M3)
                acc_q <= mac_sum;
            if (state_q == ST_M2 || state_q == ST_M4)
                dout_q <= mac_sum;
        end
    end

    assign sym_rdy = (state_q == ST_IDLE);
    assign ovr     = ovr_q;
    assign dout_en = dout_en_q;
    assign dout    = dout_q;

endmodule
